xbar_switch_rr: RTL
===================

Name: xbar_switch_rr

Overview:
- Parametrised M_IN x N_OUT flit crossbar: successor to the fixed 6-direction router switch.
- Per output: route decode, round-robin arbitration across all inputs, one registered output stage with valid/avail flow control.
- Sits between the VC input buffers and the link output ports of the router.
- Optional packet locking holds a grant from head flit to tail flit (wormhole).

Parameters:
- M_IN, 12, number of input channels (VC_NUM * PORT_NUM); must be >= 2.
- N_OUT, 6, number of output ports; must be <= 2**ROUTE_LEN - 1.
- FLIT_SIZE, 64, flit width in bits.
- ROUTE_LEN, 3, width of each per-input route field.
- TAIL_BIT, FLIT_SIZE-1, flit bit index marking the tail flit; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in  input  M_IN*FLIT_SIZE  input flits; channel i occupies bits [i*FLIT_SIZE +: FLIT_SIZE].
- route_in  input  M_IN*ROUTE_LEN  per-input destination; value r in 1..N_OUT selects output r-1.
- in_valid  input  M_IN  input flit present.
- in_avail  output  M_IN  input flit accepted this cycle (combinational).
- out_valid  output  N_OUT  registered output flit present.
- out_avail  input  N_OUT  downstream accepts the output flit.
- out  output  N_OUT*FLIT_SIZE  registered output flits.

Behaviour:
- Reset: registered outputs, round-robin pointers and locks are cleared.
  - Synchronous: takes effect at the clk edge with rst=1.
  - out_valid=0, out=0, all RR pointers=0, all locks cleared.
  - Any flit held in an output stage is discarded.
  - in_avail is 0 while rst=1.
- Route decode:
  - req[o][i] = in_valid[i] && route_in[i] == o+1.
  - Route 0 or route > N_OUT never requests any output, so in_avail[i] stays 0 (input stalls).
- Output stage o can load when !out_valid[o] || out_avail[o], so back-to-back streaming runs at 1 flit/cycle.
- Arbitration (per output, same cycle):
  - If stage o can load, grant the lowest index i >= ptr[o] (wrapping modulo M_IN) with req[o][i].
  - in_avail[i] = 1 iff input i is granted by the output it routes to.
  - Transfer happens when in_valid[i] && in_avail[i].
- Pointer update: on each grant at output o, ptr[o] <= (granted index + 1) mod M_IN. With no grant, ptr[o] holds.
- Latency: flit accepted at edge k appears on out/out_valid after edge k.
- Output register:
  - On grant: out[o] <= in[i], out_valid[o] <= 1.
  - Else if out_avail[o]: out_valid[o] <= 0; out[o] holds its value.
- Simultaneous drain and fill: stage o delivers its old flit and captures the new one in the same edge, so out_valid stays 1.
- Independent outputs: different outputs grant different inputs in the same cycle with no interaction.
- Each input targets exactly one output per cycle, so no input receives two grants.
- out_avail held low: the stage holds out/out_valid stable and grants nothing; requesters see in_avail=0.

Optional Feature:
- Macro: XBAR_SWITCH_PKT_LOCK_EN.
- Defined:
  - A grant to input i on output o sets lock[o] with owner i.
  - While locked, only the owner can be granted on o; other requesters wait even if the owner is idle.
  - The lock clears on the edge that accepts a flit from the owner with in[i][TAIL_BIT]=1.
  - A single-flit packet (head flit already has TAIL_BIT=1) locks and unlocks on the same edge.
  - ptr[o] advances only when the lock clears.
- Undefined: arbitration is per flit; no lock state is synthesised and TAIL_BIT is ignored.

Decomposition:
- Package xbar_switch_pkg holds:
  - FLIT_SIZE and ROUTE_LEN defaults.
  - DIR_XPOS..DIR_ZNEG route constants (1..6).
  - Helper function clog2_safe for pointer widths.
- Sub-module rr_arbiter: parameter N, with inputs req[N] and ptr, outputs onehot grant[N] and grant_idx. Instantiated N_OUT times.
- Pointer and lock registers stay in the top module.

Test Plan:
- Basic transfer (defaults): in_valid[3]=1, route_in[3]=2, in[3]=0xA5, out_avail all 1 -> in_avail[3]=1 that cycle; next cycle out_valid[1]=1 and out[1]=0xA5; all other out_valid remain 0.
- Round-robin fairness: inputs 0, 5 and 11 continuously request output 0 with out_avail[0]=1 -> grants follow 0,5,11,0,5,11; ptr[0] reads 1, then 6, then 0.
- Backpressure: out_valid[2]=1 and out_avail[2]=0 for 4 cycles while input 7 requests route 3 -> in_avail[7]=0 and out[2] stable for those 4 cycles; raising out_avail[2] accepts input 7, and the next edge shows input 7's flit with out_valid[2] still 1.
- Invalid route and reset: route_in[4]=0 or 7 with in_valid[4]=1 -> in_avail[4]=0 and no out_valid. Asserting rst while out_valid=6'b111111 -> all out_valid=0, out=0 after the edge, and the next grant on each output starts from input 0.
- Parallel outputs: 6 inputs, each targeting a distinct output, in one cycle -> all 6 in_avail=1 and all 6 out_valid=1 the next cycle with the matching data.
- PKT_LOCK_EN: input 2 sends a 3-flit packet (tail on the third flit) to output 0 while input 1 requests output 0 every cycle -> output 0 delivers 2,2,2, then 1. Without the macro, output 0 delivers 2,1,2,1,...

Source files
------------

// File: rtl/xbar_switch_pkg.sv
// Shared constants and helpers for the parametrised round-robin flit crossbar.
// Used by xbar_switch_rr and rr_arbiter; optional wormhole locking is XBAR_SWITCH_PKT_LOCK_EN.
package xbar_switch_pkg;

   localparam int FLIT_SIZE_DEF = 64;
   localparam int ROUTE_LEN_DEF = 3;

   // Route values of the legacy 6-direction router; 0 means "no destination".
   typedef enum logic [2:0] {
      DIR_NONE = 3'd0,
      DIR_XPOS = 3'd1,
      DIR_XNEG = 3'd2,
      DIR_YPOS = 3'd3,
      DIR_YNEG = 3'd4,
      DIR_ZPOS = 3'd5,
      DIR_ZNEG = 3'd6
   } dir_e;

   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/xbar_switch_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping modulo N, and reports the winner both one-hot and as an index.
module rr_arbiter
   import xbar_switch_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = clog2_safe(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] grant_idx_o
);

   int          idx;
   logic [PW-1:0] sel;
   logic        found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      sel         = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         sel = PW'(idx);
         if (!found && req_i[sel]) begin
            found        = 1'b1;
            grant_o[sel] = 1'b1;
            grant_idx_o  = sel;
         end
      end
   end

endmodule

// File: rtl/xbar_switch_rr.sv
// M_IN x N_OUT flit crossbar with per-output round-robin arbitration and one
// registered output stage. Define XBAR_SWITCH_PKT_LOCK_EN for head-to-tail packet locking.
module xbar_switch_rr
   import xbar_switch_pkg::*;
#(
   parameter int M_IN      = 12,
   parameter int N_OUT     = 6,
   parameter int FLIT_SIZE = FLIT_SIZE_DEF,
   parameter int ROUTE_LEN = ROUTE_LEN_DEF,
   parameter int TAIL_BIT  = FLIT_SIZE - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [M_IN*FLIT_SIZE-1:0]  in,
   input  logic [M_IN*ROUTE_LEN-1:0]  route_in,
   input  logic [M_IN-1:0]            in_valid,
   output logic [M_IN-1:0]            in_avail,
   output logic [N_OUT-1:0]           out_valid,
   input  logic [N_OUT-1:0]           out_avail,
   output logic [N_OUT*FLIT_SIZE-1:0] out
);

   localparam int PW = clog2_safe(M_IN);

   logic [N_OUT-1:0][M_IN-1:0] grant_all;

   for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
      logic [M_IN-1:0]      req;
      logic [M_IN-1:0]      req_arb;
      logic [M_IN-1:0]      grant;
      logic [PW-1:0]        grant_idx;
      logic [PW-1:0]        next_idx;
      logic [PW-1:0]        ptr_q, ptr_d;
      logic                 can_load;
      logic                 any_grant;
      logic [FLIT_SIZE-1:0] sel_flit;
      logic                 out_valid_q, out_valid_d;
      logic [FLIT_SIZE-1:0] out_q, out_d;

      // Out-of-range routes (0 or > N_OUT) match no output, so such inputs stall.
      always_comb begin
         req = '0;
         for (int i = 0; i < M_IN; i++) begin
            req[i] = in_valid[i] &&
                     (route_in[i*ROUTE_LEN +: ROUTE_LEN] == ROUTE_LEN'(gi + 1));
         end
      end

      assign can_load  = !out_valid_q || out_avail[gi];
      assign any_grant = |grant;
      assign sel_flit  = in[grant_idx*FLIT_SIZE +: FLIT_SIZE];
      assign next_idx  = (grant_idx == PW'(M_IN - 1)) ? '0 : grant_idx + 1'b1;

`ifdef XBAR_SWITCH_PKT_LOCK_EN
      logic          lock_q, lock_d;
      logic [PW-1:0] owner_q, owner_d;
      logic [M_IN-1:0] owner_mask;

      // While a packet is in flight only its owner may win, even if it is idle.
      always_comb begin
         owner_mask          = '0;
         owner_mask[owner_q] = 1'b1;
         req_arb             = '0;
         if (can_load && !rst) begin
            req_arb = lock_q ? (req & owner_mask) : req;
         end
      end

      always_comb begin
         lock_d  = lock_q;
         owner_d = owner_q;
         ptr_d   = ptr_q;
         if (any_grant) begin
            if (sel_flit[TAIL_BIT]) begin
               lock_d = 1'b0;
               ptr_d  = next_idx;
            end else begin
               lock_d  = 1'b1;
               owner_d = grant_idx;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
         end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
         end
      end
`else
      always_comb begin
         req_arb = '0;
         if (can_load && !rst) begin
            req_arb = req;
         end
      end

      always_comb begin
         ptr_d = ptr_q;
         if (any_grant) begin
            ptr_d = next_idx;
         end
      end
`endif

      rr_arbiter #(
         .N  (M_IN),
         .PW (PW)
      ) u_arb (
         .req_i       (req_arb),
         .ptr_i       (ptr_q),
         .grant_o     (grant),
         .grant_idx_o (grant_idx)
      );

      // A grant overwrites the stage even when the old flit drains on the same edge.
      always_comb begin
         out_valid_d = out_valid_q;
         out_d       = out_q;
         if (any_grant) begin
            out_valid_d = 1'b1;
            out_d       = sel_flit;
         end else if (out_avail[gi]) begin
            out_valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ptr_q       <= '0;
         end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ptr_q       <= ptr_d;
         end
      end

      assign grant_all[gi]                   = grant;
      assign out_valid[gi]                   = out_valid_q;
      assign out[gi*FLIT_SIZE +: FLIT_SIZE]  = out_q;
   end

   // Each input routes to one output, so OR-ing the per-output grants is exact.
   always_comb begin
      in_avail = '0;
      for (int o = 0; o < N_OUT; o++) begin
         in_avail = in_avail | grant_all[o];
      end
   end

endmodule
